// File: rtl/perspective_divide.sv
// perspective_divide
//   Projects a Q16.16 vertex (x, y, z) to (x/z, y/z) using an external
//   pipelined fixed-point divider. Each accepted vertex issues two divider
//   transactions (x/z then y/z). Results come back in order, are paired by a
//   toggle bit and pushed into a small result FIFO. A credit counter limits
//   the vertices in flight to FIFO_DEPTH, so the FIFO write can never be
//   blocked even though the divider has no backpressure.
//
//   After reset the block sits in DRAIN for DRAIN_CYCLES cycles, discarding
//   any divider results still emerging from work abandoned by the reset.
//
// Parameters
//   FIFO_DEPTH   result pairs buffered = max vertices in flight
//   DRAIN_CYCLES post-reset cycles during which divider results are dropped
//
// Ports
//   clk, rstn                         clock, async active-low reset
//   in_valid/in_ready/in_x/in_y/in_z  vertex input handshake
//   out_valid/out_ready/out_x/out_y   projected point output handshake
//   out_zdiv                          vertex had z == 0 (zero-guard build only)
//   div_operands_valid/div_ready      divider issue handshake
//   div_dividend/div_divisor          divider operands
//   div_result_valid/div_result       divider result strobe and quotient
//
// Configuration macro
//   PERSPECTIVE_DIVIDE_ZERO_GUARD_EN  when defined, z == 0 divides by 1.0
//                                     instead and flags out_zdiv.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_DRAIN   | post-reset, dropping stale divider results, in_ready = 0
// S_IDLE    | waiting for a vertex (in_ready when credits remain)
// S_ISSUE_X | presenting x / z to the divider
// S_ISSUE_Y | presenting y / z to the divider

module perspective_divide #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic        out_zdiv,
  output logic        div_operands_valid,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_ready,
  input  logic        div_result_valid,
  input  logic [31:0] div_result
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CW-1:0] CREDITS_MAX = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_DRAIN   = 2'd0,
    S_IDLE    = 2'd1,
    S_ISSUE_X = 2'd2,
    S_ISSUE_Y = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [31:0]   x_q, x_d;
  logic [31:0]   y_q, y_d;
  logic [31:0]   divisor_q, divisor_d;
  logic [31:0]   res_x_q, res_x_d;
  logic          toggle_q, toggle_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_x_q [FIFO_DEPTH];
  logic [31:0]   mem_x_d [FIFO_DEPTH];
  logic [31:0]   mem_y_q [FIFO_DEPTH];
  logic [31:0]   mem_y_d [FIFO_DEPTH];

  logic        in_accept;
  logic        out_hs;
  logic        result_take;
  logic        fifo_wr;
  logic [31:0] in_divisor;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_ready    = (state_q == S_IDLE) && (credits_q != '0);
  assign in_accept   = in_valid && in_ready;
  assign out_valid   = (count_q != '0);
  assign out_hs      = out_valid && out_ready;
  // Results arriving during DRAIN belong to vertices abandoned by reset.
  assign result_take = div_result_valid && (state_q != S_DRAIN);
  assign fifo_wr     = result_take && toggle_q;

  assign div_operands_valid = (state_q == S_ISSUE_X) || (state_q == S_ISSUE_Y);
  assign div_dividend       = (state_q == S_ISSUE_Y) ? y_q : x_q;
  assign div_divisor        = divisor_q;

  assign out_x = mem_x_q[rd_ptr_q];
  assign out_y = mem_y_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    divisor_d   = divisor_q;
    case (state_q)
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_IDLE;
        else                           drain_cnt_d = drain_cnt_q + DW'(1);
      end
      S_IDLE: begin
        if (in_accept) begin
          x_d       = in_x;
          y_d       = in_y;
          divisor_d = in_divisor;
          state_d   = S_ISSUE_X;
        end
      end
      S_ISSUE_X: if (div_ready) state_d = S_ISSUE_Y;
      S_ISSUE_Y: if (div_ready) state_d = S_IDLE;
      default:   state_d = S_DRAIN;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    case ({in_accept, out_hs})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    toggle_d = toggle_q;
    res_x_d  = res_x_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_x_d  = mem_x_q;
    mem_y_d  = mem_y_q;
    if (result_take) begin
      toggle_d = ~toggle_q;
      if (!toggle_q) res_x_d = div_result;
    end
    if (fifo_wr) begin
      mem_x_d[wr_ptr_q] = res_x_q;
      mem_y_d[wr_ptr_q] = div_result;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (out_hs) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({fifo_wr, out_hs})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_DRAIN;
      drain_cnt_q <= '0;
      credits_q   <= CREDITS_MAX;
      x_q         <= '0;
      y_q         <= '0;
      divisor_q   <= '0;
      res_x_q     <= '0;
      toggle_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_x_q     <= '{default: '0};
      mem_y_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      credits_q   <= credits_d;
      x_q         <= x_d;
      y_q         <= y_d;
      divisor_q   <= divisor_d;
      res_x_q     <= res_x_d;
      toggle_q    <= toggle_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_x_q     <= mem_x_d;
      mem_y_q     <= mem_y_d;
    end
  end

`ifdef PERSPECTIVE_DIVIDE_ZERO_GUARD_EN
  // The zero flag must follow its own vertex through the divider while newer
  // vertices are accepted. Vertices finish in acceptance order, so the flag
  // is parked at the FIFO slot the vertex will occupy; credits guarantee that
  // slot is free at acceptance time.
  logic          in_zero;
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic          zdiv_mem_q [FIFO_DEPTH];
  logic          zdiv_mem_d [FIFO_DEPTH];

  assign in_zero    = (in_z == 32'h0);
  assign in_divisor = in_zero ? 32'h0001_0000 : in_z;
  assign out_zdiv   = zdiv_mem_q[rd_ptr_q];

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    zdiv_mem_d  = zdiv_mem_q;
    if (in_accept) begin
      zdiv_mem_d[alloc_ptr_q] = in_zero;
      alloc_ptr_d             = ptr_inc(alloc_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alloc_ptr_q <= '0;
      zdiv_mem_q  <= '{default: 1'b0};
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      zdiv_mem_q  <= zdiv_mem_d;
    end
  end
`else
  assign in_divisor = in_z;
  assign out_zdiv   = 1'b0;
`endif

endmodule

// File: tb/tb_perspective_divide.sv
module tb_perspective_divide;

  localparam int FIFO_DEPTH = 4;
  localparam int DRAIN      = 40;
  localparam int DIV_LAT    = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y, in_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x, out_y;
  logic        out_zdiv;
  logic        div_operands_valid;
  logic [31:0] div_dividend, div_divisor;
  logic        div_ready;
  logic        div_result_valid;
  logic [31:0] div_result;

  always #5 clk = ~clk;

  perspective_divide #(.FIFO_DEPTH(FIFO_DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_x              (in_x),
    .in_y              (in_y),
    .in_z              (in_z),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_x             (out_x),
    .out_y             (out_y),
    .out_zdiv          (out_zdiv),
    .div_operands_valid(div_operands_valid),
    .div_dividend      (div_dividend),
    .div_divisor       (div_divisor),
    .div_ready         (div_ready),
    .div_result_valid  (div_result_valid),
    .div_result        (div_result)
  );

  typedef struct packed {logic [31:0] x; logic [31:0] y; logic [31:0] z;} vtx_t;
  typedef struct packed {logic [31:0] x; logic [31:0] y; logic zdiv;} res_t;

  vtx_t vq[$];
  res_t outs[$];
  int   out_cyc[$];
  int   out_acc[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_mon = 0;
  int   div_hs_cnt = 0;
  int   rv_cnt = 0;
  int   ov_cnt = 0;
  int   last_rv_cyc = 0;
  int   ov_rise_cyc = 0;
  logic ov_prev = 1'b0;

  logic        pv [DIV_LAT];
  logic [31:0] pd [DIV_LAT];

  // Reference Q16.16 divide; divide-by-zero saturates to max positive.
  function automatic logic [31:0] fx_div(input logic [31:0] a, input logic [31:0] b);
    longint n, q;
    if (b == 32'h0) return 32'h7FFF_FFFF;
    n = longint'($signed(a)) * 64'sd65536;
    q = n / longint'($signed(b));
    return 32'(q);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_mon <= acc_mon + 1;
    if (div_operands_valid && div_ready) div_hs_cnt <= div_hs_cnt + 1;
    if (div_result_valid) begin
      rv_cnt      <= rv_cnt + 1;
      last_rv_cyc <= cyc;
    end
    ov_prev <= out_valid;
    if (out_valid && !ov_prev) ov_rise_cyc <= cyc;
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (out_valid && out_ready) begin
      outs.push_back({out_x, out_y, out_zdiv});
      out_cyc.push_back(cyc);
      out_acc.push_back(acc_mon);
    end
  end

  task automatic push_vtx(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    vtx_t v;
    v.x = x; v.y = y; v.z = z;
    vq.push_back(v);
  endtask

  task automatic clear_outs();
    outs.delete();
    out_cyc.delete();
    out_acc.delete();
  endtask

  task automatic wait_outs(input int n, input int limit, input string tag);
    int k = 0;
    while (outs.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (outs.size() < n) begin
      failures++;
      $display("FAIL %s timeout: outputs=%0d required=%0d", tag, outs.size(), n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    out_ready = 1'b0;
    div_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (div_operands_valid !== 1'b0) begin failures++; $display("FAIL reset_div_valid got=%b exp=0", div_operands_valid); end
    checks++; if (out_x !== 32'h0) begin failures++; $display("FAIL reset_out_x got=%h exp=0", out_x); end
    checks++; if (out_y !== 32'h0) begin failures++; $display("FAIL reset_out_y got=%h exp=0", out_y); end
    checks++; if (out_zdiv !== 1'b0) begin failures++; $display("FAIL reset_out_zdiv got=%b exp=0", out_zdiv); end
  endtask

  task automatic test_drain();
    int first = -1;
    rstn = 1'b1;
    for (int k = 1; k <= DRAIN + 5; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first != DRAIN) begin failures++; $display("FAIL drain_length got=%0d exp=%0d", first, DRAIN); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    clear_outs();
    push_vtx(32'h0004_0000, 32'h0002_0000, 32'h0002_0000);
    wait_outs(1, 100, "basic");
    repeat (3) @(negedge clk);
    if (outs.size() >= 1) begin
      checks++; if (outs[0].x !== 32'h0002_0000) begin failures++; $display("FAIL basic_x got=%h exp=00020000", outs[0].x); end
      checks++; if (outs[0].y !== 32'h0001_0000) begin failures++; $display("FAIL basic_y got=%h exp=00010000", outs[0].y); end
      checks++; if (outs[0].zdiv !== 1'b0) begin failures++; $display("FAIL basic_zdiv got=%b exp=0", outs[0].zdiv); end
    end
    checks++;
    if (ov_rise_cyc != last_rv_cyc + 1) begin
      failures++; $display("FAIL out_valid_latency got=%0d exp=%0d", ov_rise_cyc - last_rv_cyc, 1);
    end
  endtask

  task automatic test_div_stall();
    int k = 0;
    int base_hs;
    out_ready = 1'b1;
    div_ready = 1'b0;
    clear_outs();
    base_hs = div_hs_cnt;
    push_vtx(32'h0006_0000, 32'h0003_0000, 32'h0003_0000);
    while (div_operands_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({div_operands_valid, div_dividend, div_divisor} !== {1'b1, 32'h0006_0000, 32'h0003_0000}) begin
        failures++;
        $display("FAIL stall_operands cycle=%0d got=%b/%h/%h exp=1/00060000/00030000", i, div_operands_valid, div_dividend, div_divisor);
      end
      @(negedge clk);
    end
    div_ready = 1'b1;
    wait_outs(1, 60, "stall");
    repeat (10) @(negedge clk);
    checks++; if (div_hs_cnt - base_hs != 2) begin failures++; $display("FAIL stall_div_txns got=%0d exp=2", div_hs_cnt - base_hs); end
    if (outs.size() >= 1) begin
      checks++; if (outs[0].x !== 32'h0002_0000) begin failures++; $display("FAIL stall_x got=%h exp=00020000", outs[0].x); end
      checks++; if (outs[0].y !== 32'h0001_0000) begin failures++; $display("FAIL stall_y got=%h exp=00010000", outs[0].y); end
    end
  endtask

  task automatic test_zero_guard();
    out_ready = 1'b1;
    clear_outs();
    push_vtx(32'h0003_0000, 32'h0001_0000, 32'h0000_0000);
    push_vtx(32'h0004_0000, 32'h0002_0000, 32'h0002_0000);
    wait_outs(2, 100, "zero_guard");
    if (outs.size() >= 2) begin
`ifdef PERSPECTIVE_DIVIDE_ZERO_GUARD_EN
      checks++; if (outs[0].x !== 32'h0003_0000) begin failures++; $display("FAIL zg_x got=%h exp=00030000", outs[0].x); end
      checks++; if (outs[0].y !== 32'h0001_0000) begin failures++; $display("FAIL zg_y got=%h exp=00010000", outs[0].y); end
      checks++; if (outs[0].zdiv !== 1'b1) begin failures++; $display("FAIL zg_zdiv got=%b exp=1", outs[0].zdiv); end
`else
      checks++; if (outs[0].x !== 32'h7FFF_FFFF) begin failures++; $display("FAIL zg_x got=%h exp=7fffffff", outs[0].x); end
      checks++; if (outs[0].zdiv !== 1'b0) begin failures++; $display("FAIL zg_zdiv got=%b exp=0", outs[0].zdiv); end
`endif
      checks++; if (outs[1].x !== 32'h0002_0000) begin failures++; $display("FAIL zg_next_x got=%h exp=00020000", outs[1].x); end
      checks++; if (outs[1].zdiv !== 1'b0) begin failures++; $display("FAIL zg_next_zdiv got=%b exp=0", outs[1].zdiv); end
    end
  endtask

  task automatic test_backpressure();
    int base_acc;
    out_ready = 1'b0;
    clear_outs();
    base_acc = acc_mon;
    for (int k = 1; k <= 6; k++) push_vtx(32'(2 * k) << 16, 32'(4 * k) << 16, 32'h0002_0000);
    repeat (60) @(negedge clk);
    checks++; if (acc_mon - base_acc != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", acc_mon - base_acc); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_x !== 32'h0001_0000) begin failures++; $display("FAIL bp_head_x got=%h exp=00010000", out_x); end
    repeat (10) @(negedge clk);
    checks++; if ({out_x, out_y} !== {32'h0001_0000, 32'h0002_0000}) begin failures++; $display("FAIL bp_head_stable got=%h/%h exp=00010000/00020000", out_x, out_y); end
    out_ready = 1'b1;
    wait_outs(6, 150, "backpressure");
    repeat (3) @(negedge clk);
    if (out_acc.size() >= 1) begin
      checks++; if (out_acc[0] - base_acc != 4) begin failures++; $display("FAIL bp_accepts_before_first_out got=%0d exp=4", out_acc[0] - base_acc); end
    end
    checks++; if (acc_mon - base_acc != 6) begin failures++; $display("FAIL bp_total_accepted got=%0d exp=6", acc_mon - base_acc); end
    checks++; if (outs.size() != 6) begin failures++; $display("FAIL bp_out_count got=%0d exp=6", outs.size()); end
    for (int i = 0; i < 6 && i < outs.size(); i++) begin
      checks++;
      if ({outs[i].x, outs[i].y} !== {32'(i + 1) << 16, 32'(2 * (i + 1)) << 16}) begin
        failures++;
        $display("FAIL bp_order idx=%0d got=%h/%h exp=%h/%h", i, outs[i].x, outs[i].y, 32'(i + 1) << 16, 32'(2 * (i + 1)) << 16);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int base_acc;
    int k = 0;
    int rv_rel;
    int ov_rel;
    out_ready = 1'b1;
    div_ready = 1'b1;
    clear_outs();
    base_acc = acc_mon;
    push_vtx(32'h0008_0000, 32'h0004_0000, 32'h0002_0000);
    push_vtx(32'h000A_0000, 32'h0006_0000, 32'h0002_0000);
    push_vtx(32'h000C_0000, 32'h0008_0000, 32'h0002_0000);
    while (acc_mon - base_acc < 3 && k < 30) begin @(negedge clk); k++; end
    rstn = 1'b0;
    vq.delete();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
    checks++; if (div_operands_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_div_valid got=%b exp=0", div_operands_valid); end
    rstn = 1'b1;
    rv_rel = rv_cnt;
    ov_rel = ov_cnt;
    clear_outs();
    repeat (DRAIN - 2) @(negedge clk);
    checks++; if (rv_cnt - rv_rel != 4) begin failures++; $display("FAIL rst_stale_results got=%0d exp=4", rv_cnt - rv_rel); end
    checks++; if (ov_cnt - ov_rel != 0) begin failures++; $display("FAIL rst_stale_out_valid got=%0d exp=0", ov_cnt - ov_rel); end
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    push_vtx(32'h0009_0000, 32'h0003_0000, 32'h0003_0000);
    wait_outs(1, 60, "post_reset");
    repeat (10) @(negedge clk);
    checks++; if (outs.size() != 1) begin failures++; $display("FAIL rst_fresh_count got=%0d exp=1", outs.size()); end
    if (outs.size() >= 1) begin
      checks++; if ({outs[0].x, outs[0].y} !== {32'h0003_0000, 32'h0001_0000}) begin failures++; $display("FAIL rst_fresh_xy got=%h/%h exp=00030000/00010000", outs[0].x, outs[0].y); end
    end
  endtask

  task automatic test_throughput();
    int base_acc;
    out_ready = 1'b1;
    div_ready = 1'b1;
    clear_outs();
    base_acc = acc_mon;
    for (int k = 1; k <= 12; k++) push_vtx(32'(2 * k) << 16, 32'(4 * k) << 16, 32'h0002_0000);
    wait_outs(12, 200, "throughput");
    repeat (3) @(negedge clk);
    checks++; if (acc_mon - base_acc != 12) begin failures++; $display("FAIL tp_accepted got=%0d exp=12", acc_mon - base_acc); end
    for (int i = 4; i < 12 && i < out_cyc.size(); i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i - 1] != 3) begin
        failures++; $display("FAIL tp_interval idx=%0d got=%0d exp=3", i, out_cyc[i] - out_cyc[i - 1]);
      end
    end
    for (int i = 0; i < 12 && i < outs.size(); i++) begin
      checks++;
      if ({outs[i].x, outs[i].y} !== {32'(i + 1) << 16, 32'(2 * (i + 1)) << 16}) begin
        failures++; $display("FAIL tp_value idx=%0d got=%h/%h", i, outs[i].x, outs[i].y);
      end
    end
  endtask

  initial begin
    rstn      = 1'b0;
    out_ready = 1'b0;
    div_ready = 1'b1;
    for (int i = 0; i < DIV_LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    fork
      begin : driver
        in_valid = 1'b0;
        in_x = '0; in_y = '0; in_z = '0;
        forever begin
          @(negedge clk);
          if (vq.size() > 0) begin
            in_valid = 1'b1;
            in_x = vq[0].x; in_y = vq[0].y; in_z = vq[0].z;
          end else begin
            in_valid = 1'b0;
          end
          @(posedge clk);
          if (in_valid && in_ready && vq.size() > 0) void'(vq.pop_front());
        end
      end
      begin : divider_model
        logic        hs;
        logic [31:0] q;
        div_result_valid = 1'b0;
        div_result = '0;
        forever begin
          @(posedge clk);
          hs = div_operands_valid && div_ready;
          q  = fx_div(div_dividend, div_divisor);
          for (int i = DIV_LAT - 1; i > 0; i--) begin pv[i] = pv[i - 1]; pd[i] = pd[i - 1]; end
          pv[0] = hs;
          pd[0] = q;
          @(negedge clk);
          div_result_valid = pv[DIV_LAT - 1];
          div_result       = pd[DIV_LAT - 1];
        end
      end
    join_none

    test_reset();
    test_drain();
    test_basic();
    test_div_stall();
    test_zero_guard();
    test_backpressure();
    test_reset_midflight();
    test_throughput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/perspective_divide.md
PERSPECTIVE_DIVIDE -- requirements
Module: perspective_divide

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of result pairs buffered, which is also the maximum number of vertices in flight.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 40, the number of post-reset cycles during which divider results are discarded.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream vertex valid.
REQ-006 in_ready  output  1  vertex accepted when in_valid && in_ready.
REQ-007 in_x, in_y, in_z  input  32 each  vertex coordinates, fixed Q16.16 two's complement.
REQ-008 out_valid  output  1  projected point valid.
REQ-009 out_ready  input  1  downstream accepts the point when out_valid && out_ready.
REQ-010 out_x, out_y  output  32 each  x/z and y/z, fixed Q16.16.
REQ-011 out_zdiv  output  1  set when the vertex had z == 0.
REQ-012 div_operands_valid  output  1  drives the fixed-point divider's operands_valid.
REQ-013 div_dividend, div_divisor  output  32 each  divider operands, fixed.
REQ-014 div_ready  input  1  divider ready.
REQ-015 div_result_valid  input  1  divider result strobe; the divider has no backpressure.
REQ-016 div_result  input  32  divider quotient, fixed.

Function
REQ-017 SHALL implement the FSM states DRAIN, IDLE, ISSUE_X and ISSUE_Y.
REQ-018 In IDLE, in_ready = (credits > 0); on accept, the block SHALL register x, y, z and the zero flag, decrement credits and go to ISSUE_X.
REQ-019 In ISSUE_X, the block SHALL drive div_operands_valid=1, dividend=x, divisor=z, and go to ISSUE_Y the cycle div_ready=1.
REQ-020 In ISSUE_Y, the block SHALL drive div_operands_valid=1, dividend=y, divisor=z, and go to IDLE the cycle div_ready=1.
REQ-021 Outside ISSUE_X/ISSUE_Y, div_operands_valid SHALL be 0; in those states, operands SHALL remain stable while div_ready=0.
REQ-022 in_ready SHALL be 0 in every state except IDLE; maximum throughput is one vertex per 3 cycles.
REQ-023 The credit counter SHALL reset to FIFO_DEPTH, decrement on input accept, increment on output handshake; a simultaneous accept and output handshake SHALL leave it unchanged; it SHALL never leave the range 0..FIFO_DEPTH.
REQ-024 Results SHALL be taken in order: a toggle bit marks the first div_result_valid of a pair as x and the second as y.
REQ-025 On y, the block SHALL write {x, y, zdiv} into the FIFO; the write SHALL never be blocked, since credits guarantee space.
REQ-026 out_valid SHALL equal FIFO not-empty; out_x/out_y/out_zdiv = FIFO head, held stable while out_valid && !out_ready.
REQ-027 out_valid SHALL rise exactly 1 cycle after the div_result_valid carrying y.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous write and read with the FIFO full or empty SHALL be legal and SHALL keep the count unchanged.
REQ-029 DRAIN: after rstn deasserts, the block SHALL stay in DRAIN for DRAIN_CYCLES cycles with in_ready=0, ignoring div_result_valid, and SHALL then go to IDLE.

Reset
REQ-030 While rstn=0, the block SHALL drive: state=DRAIN, drain counter=0, credits=FIFO_DEPTH, FIFO empty, toggle=0, in_ready=0, out_valid=0, div_operands_valid=0, out_x=out_y=0, out_zdiv=0.
REQ-031 Reset mid-operation SHALL abandon all in-flight vertices; divider results still emerging SHALL be absorbed by DRAIN.
REQ-032 div_result_valid seen while rstn=0 SHALL be ignored.

Configuration
REQ-033 Macro PERSPECTIVE_DIVIDE_ZERO_GUARD_EN:
REQ-034 When defined, z == 0 SHALL substitute divisor 32'h0001_0000 (1.0) for both divisions and set out_zdiv=1 for that point.
REQ-035 When undefined, z SHALL be passed unchanged (result as produced by the divider) and out_zdiv SHALL be tied to 0.

Verification
REQ-036 Bench SHALL drive x=0x0004_0000, y=0x0002_0000, z=0x0002_0000, divider model latency 8 -> out_x=0x0002_0000, out_y=0x0001_0000, out_zdiv=0.
REQ-037 Bench SHALL hold out_ready=0 and offer 6 back-to-back vertices -> exactly 4 accepted, in_ready stays 0 until the first out handshake, and outputs emerge in order with no loss.
REQ-038 Bench SHALL hold div_ready=0 for 5 cycles in ISSUE_X -> div_dividend/div_divisor stable, and exactly 2 divider transactions result per vertex.
REQ-039 Bench SHALL drive z=0, x=0x0003_0000 with the macro defined -> out_x=0x0003_0000, out_zdiv=1; with the macro undefined -> out_zdiv=0.
REQ-040 Bench SHALL pulse rstn low with 3 vertices in flight -> out_valid=0; stale div_result_valid within DRAIN_CYCLES produces no output; a fresh vertex afterwards yields correct results.
REQ-041 Bench SHALL run full FIFO with out_ready=1 at steady state -> credits oscillate without underflow, and one point per 3 cycles is sustained.
